// File: rtl/inverse_rotate_pkg.sv
// Shared constants for the lane-rotation step: geometry, FSM encoding and the
// rho offset table used by both the encoder rotate and its decoder inverse.
package inverse_rotate_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int ADDR_W    = 5;
  localparam int AMT_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [ADDR_W-1:0] lane_index(input int x, input int y);
    return ADDR_W'(5 * y + x);
  endfunction

  // Offsets indexed by lane address 5*y+x; all already reduced mod LANE_W.
  function automatic logic [AMT_W-1:0] rho_offset(input logic [ADDR_W-1:0] lane);
    logic [AMT_W-1:0] r;
    case (lane)
      5'd0:  r = 6'd0;
      5'd1:  r = 6'd1;
      5'd2:  r = 6'd62;
      5'd3:  r = 6'd28;
      5'd4:  r = 6'd27;
      5'd5:  r = 6'd36;
      5'd6:  r = 6'd44;
      5'd7:  r = 6'd6;
      5'd8:  r = 6'd55;
      5'd9:  r = 6'd20;
      5'd10: r = 6'd3;
      5'd11: r = 6'd10;
      5'd12: r = 6'd43;
      5'd13: r = 6'd25;
      5'd14: r = 6'd39;
      5'd15: r = 6'd41;
      5'd16: r = 6'd45;
      5'd17: r = 6'd15;
      5'd18: r = 6'd21;
      5'd19: r = 6'd8;
      5'd20: r = 6'd18;
      5'd21: r = 6'd2;
      5'd22: r = 6'd61;
      5'd23: r = 6'd56;
      5'd24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inverse_rotate_if.sv
// Controller handshake plus state-memory port for the inverse rotate block.
// The slave modport is the rotate block; master is controller + memory.
interface inverse_rotate_if;
  import inverse_rotate_pkg::*;

  logic              start;
  logic              finish;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [LANE_W-1:0] mem_rdata;
  logic              mem_wr;
  logic [LANE_W-1:0] mem_wdata;

  modport master (
    output start, mem_rdata,
    input  finish, busy, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  start, mem_rdata,
    output finish, busy, mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/inverse_rotate_lane_rotr.sv
// Combinational right rotator for one lane; rotating a doubled copy keeps
// amount 0 a clean pass-through without a full-width shift corner case.
module lane_rotr
  import inverse_rotate_pkg::*;
(
  input  logic [LANE_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  output logic [LANE_W-1:0] o_data
);

  logic [2*LANE_W-1:0] w_shift;

  assign w_shift = {i_data, i_data} >> i_amt;
  assign o_data  = w_shift[LANE_W-1:0];

endmodule

// File: rtl/inverse_rotate.sv
// Decoder inverse of the lane rotation: walks lanes 0..24 in place, reading,
// rotating right by rho and writing back, one lane per three cycles.
//
// state    | meaning
// ST_IDLE  | waiting for a start edge; busy low
// ST_READ  | mem_rd for lane idx
// ST_CAPT  | read data valid; rotated lane captured into r_wdata
// ST_WRITE | mem_wr of r_wdata to lane idx; idx advances
// ST_DONE  | all lanes written; finish set on exit
module inverse_rotate
  import inverse_rotate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  inverse_rotate_if.slave  bus
);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_start_d;
  logic              r_finish;
  logic [LANE_W-1:0] r_wdata;
  logic              w_start_edge;
  logic [LANE_W-1:0] w_rot;

  assign w_start_edge = bus.start & ~r_start_d;

  lane_rotr u_rotr (
    .i_data (bus.mem_rdata),
    .i_amt  (rho_offset(r_idx)),
    .o_data (w_rot)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_edge) w_next = ST_READ;
      ST_READ:  w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_WRITE;
      ST_WRITE: w_next = (r_idx == ADDR_W'(NUM_LANES - 1)) ? ST_DONE : ST_READ;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_idx     <= '0;
      r_finish  <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_start_d <= bus.start;
      case (r_state)
        ST_IDLE: if (w_start_edge) begin
          r_idx    <= '0;
          r_finish <= 1'b0;
        end
        ST_CAPT:  r_wdata <= w_rot;
        ST_WRITE: r_idx   <= r_idx + 1'b1;
        ST_DONE:  r_finish <= 1'b1;
        default: ;
      endcase
    end
  end

  // Address is forced to 0 outside strobe cycles so the bus stays quiet.
  always_comb begin
    bus.mem_rd    = (r_state == ST_READ);
    bus.mem_wr    = (r_state == ST_WRITE);
    bus.mem_addr  = (r_state == ST_READ || r_state == ST_WRITE) ? r_idx : '0;
    bus.mem_wdata = r_wdata;
    bus.busy      = (r_state != ST_IDLE);
    bus.finish    = r_finish;
  end

endmodule
